dbus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the shared CPU data bus. Sits between the darkriscv data port (master 0) and an auxiliary master 1, such as a motor-driver or debug DMA, on one side, and the 1-cycle synchronous RAM and the IO register block on the other. It serialises accesses and decodes RAM vs IO from address bit 28. It returns byte-lane-masked read data through a single registered-select mux, so the RAM and IO read paths never drive the same net.

---
 rtl/dbus_pkg.sv | 15 +
 rtl/dbus_lane_mask.sv | 14 +
 rtl/dbus_arbiter.sv | 130 +++++++++++++
 tb/tb_dbus_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared types and defaults for the data-bus arbiter
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dbus_state_t;

  typedef logic dbus_owner_t;

  localparam int DBUS_IO_SEL_BIT = 28;
  localparam int DBUS_RAM_ADDR_W = 10;

endpackage

// File: rtl/dbus_lane_mask.sv
// rtl/dbus_lane_mask.sv - zeroes byte lanes of a data word whose enable is low
module dbus_lane_mask #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   masked
);

  for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_lane
    assign masked[8*i +: 8] = be[i] ? data[8*i +: 8] : 8'h00;
  end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master arbiter/sequencer for RAM and IO; DBUS_RR_EN selects round-robin
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_ADDR_W = DBUS_RAM_ADDR_W,
  parameter int IO_SEL_BIT = DBUS_IO_SEL_BIT
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    m0_valid,
  output logic                    m0_ready,
  input  logic [31:0]             m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  input  logic                    m0_we,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic                    m0_rvalid,
  input  logic                    m1_valid,
  output logic                    m1_ready,
  input  logic [31:0]             m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic                    m1_we,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    m1_rvalid,
  output logic                    ram_en,
  output logic                    io_en,
  output logic                    mem_we,
  output logic [RAM_ADDR_W-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  input  logic [DATA_WIDTH-1:0]   io_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  dbus_state_t            state, next_state;
  dbus_owner_t            grant, owner;
  logic                   accept;
  logic                   target, we_q;
  logic [RAM_ADDR_W-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [BE_W-1:0]        be_q;
  logic [31:0]            sel_addr;
  logic                   unused_addr_bits;
  logic [DATA_WIDTH-1:0]  rd_src, rd_masked, resp_data;

  assign accept = (state == IDLE) && (m0_valid || m1_valid);

`ifdef DBUS_RR_EN
  dbus_owner_t last_grant;

  // On a conflict, the master that did not win last time takes the bus.
  always_comb begin
    if (m0_valid && m1_valid) grant = ~last_grant;
    else                      grant = !m0_valid;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)  last_grant <= 1'b1;
    else if (accept)  last_grant <= grant;
  end
`else
  assign grant = !m0_valid;
`endif

  assign m0_ready = accept && (grant == 1'b0);
  assign m1_ready = accept && (grant == 1'b1);

  assign sel_addr         = grant ? m1_addr : m0_addr;
  assign unused_addr_bits = ^sel_addr;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state   <= IDLE;
      owner   <= 1'b0;
      target  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        owner   <= grant;
        target  <= sel_addr[IO_SEL_BIT];
        we_q    <= grant ? m1_we : m0_we;
        addr_q  <= sel_addr[RAM_ADDR_W-1:0];
        wdata_q <= grant ? m1_wdata : m0_wdata;
        be_q    <= grant ? m1_be : m0_be;
      end
    end
  end

  assign ram_en    = (state == ISSUE) && !target;
  assign io_en     = (state == ISSUE) && target;
  assign mem_we    = (state == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  // The read source is picked by the registered target, so only one path reaches rdata.
  assign rd_src = target ? io_rdata : ram_rdata;

  dbus_lane_mask #(.DATA_WIDTH(DATA_WIDTH)) u_rd_mask (
    .data   (rd_src),
    .be     (be_q),
    .masked (rd_masked)
  );

  assign resp_data = we_q ? '0 : rd_masked;

  assign m0_rvalid = (state == RESP) && (owner == 1'b0);
  assign m1_rvalid = (state == RESP) && (owner == 1'b1);
  assign m0_rdata  = m0_rvalid ? resp_data : '0;
  assign m1_rdata  = m1_rvalid ? resp_data : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - scoreboard bench for dbus_arbiter (either DBUS_RR_EN build)
module tb_dbus_arbiter;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        m0_valid, m0_ready, m0_we, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_valid, m1_ready, m1_we, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        ram_en, io_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, ram_rdata, io_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int rvalid_seen = 0;
  logic [32:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  dbus_arbiter dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_we(m0_we), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_we(m1_we), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_en(ram_en), .io_en(io_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .ram_rdata(ram_rdata), .io_rdata(io_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] addr, input logic [3:0] be,
                                              input logic we);
    logic [31:0] src, r;
    src = addr[28] ? io_rdata : ram_rdata;
    r = '0;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = src[8*i +: 8];
    return we ? 32'h0 : r;
  endfunction

  task automatic drive(input bit m, input logic v, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input logic we);
    if (m) begin
      m1_valid = v; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_we = we;
    end else begin
      m0_valid = v; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_we = we;
    end
  endtask

  task automatic push_exp(input bit m, input logic [31:0] d);
    exp_q.push_back({m, d});
    pushed++;
  endtask

  task automatic access(input bit m, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic we);
    int n;
    logic rdy;
    @(posedge clk_in); #1;
    drive(m, 1'b1, addr, wdata, be, we);
    n = 0;
    do begin
      @(negedge clk_in);
      rdy = m ? m1_ready : m0_ready;
      n++;
    end while (!rdy && n < 20);
    check("ready_timeout", rdy, 1);
    if (rdy) begin
      check("other_ready", m ? m0_ready : m1_ready, 0);
      push_exp(m, model_rdata(addr, be, we));
      @(posedge clk_in); #1;
      drive(m, 1'b0, addr, wdata, be, we);
      @(negedge clk_in);
      check("issue_ram_en", ram_en, !addr[28]);
      check("issue_io_en", io_en, addr[28]);
      check("issue_mem_we", mem_we, we);
      check("issue_mem_addr", mem_addr, addr[9:0]);
      check("issue_mem_be", mem_be, be);
      if (we) check("issue_mem_wdata", mem_wdata, wdata);
      @(negedge clk_in);
      check("resp_strobes_off", {ram_en, io_en, mem_we}, 0);
      check("resp_owner_rvalid", m ? m1_rvalid : m0_rvalid, 1);
    end else begin
      drive(m, 1'b0, addr, wdata, be, we);
    end
  endtask

  always @(negedge clk_in) begin : monitor
    logic [32:0] e, got;
    if (m0_rvalid || m1_rvalid) begin
      rvalid_seen++;
      check("rvalid_onehot", m0_rvalid & m1_rvalid, 0);
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        got = m1_rvalid ? {1'b1, m1_rdata} : {1'b0, m0_rdata};
        check("resp_owner_data", got, e);
        check("nonowner_rdata", m1_rvalid ? m0_rdata : m1_rdata, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    bit w, exp_w;
    reset_n_in = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    ram_rdata = 32'h0;
    io_rdata  = 32'h0;
    repeat (2) @(negedge clk_in);
    check("rst_strobes", {m0_ready, m1_ready, m0_rvalid, m1_rvalid, ram_en, io_en, mem_we}, 0);
    check("rst_mem_fields", {mem_addr, mem_be, mem_wdata}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;

    access(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    io_rdata = 32'h1234_5678;
    access(1'b0, 32'h1000_0004, 32'h0, 4'h3, 1'b0);
    ram_rdata = 32'hAABB_CCDD;
    access(1'b1, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
    access(1'b1, 32'h0000_0008, 32'h0, 4'b1010, 1'b0);
    access(1'b1, 32'h1000_0040, 32'h0000_55AA, 4'b1100, 1'b1);
    access(1'b0, 32'h0000_03FC, 32'h0, 4'b0001, 1'b0);

    // Reset during ISSUE of a read: strobe drops at once, no response.
    @(posedge clk_in); #1;
    drive(1'b1, 1'b1, 32'h0000_0030, 32'h0, 4'hF, 1'b0);
    @(negedge clk_in);
    check("rst_mid_ready", m1_ready, 1);
    @(posedge clk_in); #1;
    drive(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0);
    @(negedge clk_in);
    check("rst_mid_ram_en_before", ram_en, 1);
    #1 reset_n_in = 1'b0;
    #1;
    check("rst_mid_strobes", {ram_en, io_en, mem_we, m0_rvalid, m1_rvalid}, 0);
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // Both masters valid continuously, starting fresh after reset.
    @(posedge clk_in); #1;
    drive(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0044, 32'h0, 4'hF, 1'b0);
    k = 0;
    n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk_in);
      n++;
      if (m0_ready || m1_ready) begin
        check("arb_ready_onehot", m0_ready & m1_ready, 0);
        w = m1_ready;
`ifdef DBUS_RR_EN
        exp_w = k[0];
`else
        exp_w = 1'b0;
`endif
        check($sformatf("arb_grant_%0d", k), w, exp_w);
        push_exp(w, 32'hAABB_CCDD);
        k++;
      end
    end
    check("arb_grant_count", k, 4);
    @(posedge clk_in); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    repeat (4) @(negedge clk_in);

    // m0 raises valid during RESP of an m1 transaction.
    @(posedge clk_in); #1;
    drive(1'b1, 1'b1, 32'h0000_0050, 32'h0, 4'hF, 1'b0);
    @(negedge clk_in);
    check("ovl_m1_ready", m1_ready, 1);
    push_exp(1'b1, 32'hAABB_CCDD);
    @(posedge clk_in); #1;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(posedge clk_in); #1;
    drive(1'b0, 1'b1, 32'h1000_0008, 32'h0, 4'hF, 1'b0);
    #1;
    check("ovl_m0_ready_resp", m0_ready, 0);
    @(negedge clk_in);
    check("ovl_m0_ready_resp_neg", m0_ready, 0);
    @(posedge clk_in); #1;
    check("ovl_m0_ready_idle", m0_ready, 1);
    push_exp(1'b0, 32'h1234_5678);
    @(posedge clk_in); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk_in);
    check("ovl_io_en", io_en, 1);
    repeat (4) @(negedge clk_in);

    check("queue_drained", exp_q.size(), 0);
    check("rvalid_count", rvalid_seen, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
